// File: rtl/ahb_vmem_slave.sv
// AHB-Lite word-organised SRAM slave: pipelined address/data phases, configurable
// wait states, byte/half/word writes, ERROR responses and write-to-read forwarding.
module ahb_vmem_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  hsel_i,
  input  logic [1:0]            htrans_i,
  input  logic [31:0]           haddr_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic                  hready_o,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic [1:0]            hresp_o
);
  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned NBYTES    = 4;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  hready_d;
  logic [1:0]            hresp_d;

  logic [32:0]           addr_diff;
  logic [IDX_W-1:0]      a_idx;
  logic [NBYTES-1:0]     a_strb;
  logic                  a_err;
  logic                  accept;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  dp_valid;
  logic                  dp_write;
  logic [IDX_W-1:0]      dp_idx;
  logic [NBYTES-1:0]     dp_strb;

  // BUSY is treated like IDLE, so only htrans_i[1] matters
  logic unused_htrans;
  assign unused_htrans = htrans_i[0];

  // Address-phase decode; the 33rd bit of the difference flags addresses below the base
  assign addr_diff = {1'b0, haddr_i} - {1'b0, BASE_ADDR};
  assign a_idx     = addr_diff[IDX_W+1:2];
  assign a_err     = addr_diff[32]
                   | (addr_diff[31:0] >= MEM_BYTES)
                   | ((hsize_i == 3'd1) & haddr_i[0])
                   | ((hsize_i == 3'd2) & (haddr_i[1:0] != 2'b00))
                   | (hsize_i > 3'd2);
  assign accept    = hsel_i & htrans_i[1] & hready_o;
  assign commit    = dp_valid & dp_write & hready_o;

  always_comb begin
    a_strb = 4'b1111;
    case (hsize_i)
      3'd0:    a_strb = 4'b0001 << haddr_i[1:0];
      3'd1:    a_strb = 4'b0011 << haddr_i[1:0];
      default: a_strb = 4'b1111;
    endcase
  end

  // Read word as it will look after a write committing on the same edge
  always_comb begin
    rd_word = mem[a_idx];
    if (commit && (dp_idx == a_idx)) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (dp_strb[b]) rd_word[8*b +: 8] = hwdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_READY, ST_ERR2: begin
        state_d = ST_READY;
        if (accept) begin
          if (a_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = ST_READY;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_READY;
    endcase
    hready_d = (state_d == ST_READY) || (state_d == ST_ERR2);
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERR : RESP_OKAY;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_READY;
      wait_cnt_q <= '0;
      hready_o   <= 1'b1;
      hresp_o    <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hready_o   <= hready_d;
      hresp_o    <= hresp_d;
    end
  end

  // Data-phase bookkeeping and read-data capture
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_strb  <= '0;
      hrdata_o <= '0;
    end else if (accept) begin
      dp_valid <= ~a_err;
      dp_write <= hwrite_i;
      dp_idx   <= a_idx;
      dp_strb  <= a_strb;
      if (!hwrite_i) hrdata_o <= a_err ? '0 : rd_word;
    end else if (hready_o) begin
      dp_valid <= 1'b0;
    end
  end

  // Storage is not reset
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (dp_strb[b]) mem[dp_idx][8*b +: 8] <= hwdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_vmem_slave.md
# ahb_vmem_slave

AHB-Lite slave SRAM that answers the vector core's VLSU bus master (and the scalar core's data port via the interconnect). It is a word-organised memory with pipelined address and data phases and a configurable number of wait states. It supports byte, halfword and word writes, and returns an ERROR response for out-of-range, misaligned or unsupported-size accesses. Within one transfer it forwards write data to a back-to-back read of the same word, so the VLSU sees coherent data.

## Interface
- DATA_WIDTH, 32, bus data width; only 32 is supported.
- MEM_DEPTH, 1024, number of 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.
- WAIT_STATES, 0, data-phase stall cycles per OKAY transfer, range 0..15.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- resetn_i  in  1  reset, asynchronous, active-low.
- hsel_i  in  1  slave select from the address decoder.
- htrans_i  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ; BUSY is treated as IDLE.
- haddr_i  in  32  byte address (address phase).
- hwrite_i  in  1  1 = write (address phase).
- hsize_i  in  3  0 byte, 1 half, 2 word; 3..7 are unsupported.
- hwdata_i  in  32  write data (data phase), little-endian lanes.
- hready_o  out  1  transfer done / slave ready; point-to-point, this signal is also the master's hready_i.
- hrdata_o  out  32  read data; full word, the master extracts byte lanes.
- hresp_o  out  2  00 OKAY, 01 ERROR.

## Operation
- **Accept condition:** a transfer is accepted at a rising edge when hsel_i & htrans_i[1] & hready_o. At acceptance the block latches:
  - the word index, (haddr_i-BASE_ADDR)>>2;
  - the byte offset haddr_i[1:0], hwrite_i and hsize_i;
  - an error flag.
- **Error flag** is set if any of the following holds:
  - haddr_i < BASE_ADDR, or haddr_i-BASE_ADDR >= 4*MEM_DEPTH;
  - hsize_i==1 and haddr_i[0]==1;
  - hsize_i==2 and haddr_i[1:0]!=0;
  - hsize_i > 2.
- **Byte strobes** (from latched size and offset):
  - byte: 1<<off;
  - half: 4'b0011<<off;
  - word: 4'b1111.
- **FSM states:** READY, WAIT, ERR1, ERR2.
  - READY: hready_o=1, hresp_o=OKAY. On acceptance of an erroring transfer go to ERR1. On acceptance of a good transfer with WAIT_STATES>0, go to WAIT and load wait_cnt=WAIT_STATES. Otherwise stay in READY; the next cycle is the data phase.
  - WAIT: hready_o=0, hresp_o=OKAY. Decrement wait_cnt each cycle; when wait_cnt==1, go to READY, whose first cycle completes the data phase. No transfer is accepted in WAIT.
  - ERR1: hready_o=0, hresp_o=ERROR; go to ERR2 unconditionally.
  - ERR2: hready_o=1, hresp_o=ERROR. The next transfer may be accepted here under the normal accept rule; follow the same next-state rules as READY.
- **Write commit:** a good write commits hwdata_i through the strobes at the edge that ends its data phase (the edge where hready_o==1). An erroring write never modifies memory.
- **Read capture:** a good read captures the array word at acceptance into the hrdata register. The value is held until the next read is accepted, so it stays stable through the wait states.
- **Forwarding:** if a read is accepted at the same edge as a pending write commits to the same word, the captured data is the merge: new bytes where the strobe is 1, old bytes elsewhere.
- **Erroring read:** the hrdata register is set to 0.
- **Memory contents** are not reset.
- **Reset** (asynchronous, any time, including mid-transfer):
  - state=READY, hready_o=1, hresp_o=OKAY, hrdata_o=0;
  - the pending data phase is discarded and the pending write is not committed.

## Timing
- **Zero-wait case:** a transfer accepted at edge T has its data phase in cycle T..T+1. hready_o=1 and hrdata_o is valid in that cycle, and the write commits at edge T+1.
- **Zero-wait throughput:** back-to-back transfers run at 1 per cycle with no bubbles.
- **Wait-state latency:** with WAIT_STATES=N, the data phase lasts N+1 cycles. hready_o is low for the first N cycles, and the peak rate is 1 transfer per N+1 cycles.
- **Error response:** always exactly 2 cycles (ERR1, ERR2), independent of WAIT_STATES.
- **Outputs** are driven only from registers and the state; there is no combinational path from inputs to hready_o, hresp_o or hrdata_o.

## Test plan
- **Reset values:** assert resetn_i -> hready_o=1, hresp_o=00 and hrdata_o=0 immediately, with no clock edge required.
- **Word write/read, WAIT_STATES=0:**
  - stimulus: write 0xDEADBEEF to 0x10, then read 0x10 in back-to-back cycles;
  - response: hrdata_o=0xDEADBEEF in the read data phase with the forwarded value, hready_o held at 1 throughout.
- **Byte/half writes:**
  - stimulus: word 0x11223344 at 0x20, then byte 0xAA to 0x21, then half 0xBBCC to 0x22, then read 0x20;
  - response: the read returns 0xBBCCAA44.
- **Errors:** each of the following gives ERR1 (hready_o=0, hresp_o=01), then ERR2 (hready_o=1, hresp_o=01), and memory is unchanged:
  - half access to 0x31;
  - word access to 0x32;
  - hsize_i=3;
  - address 4*MEM_DEPTH.
- **WAIT_STATES=3:**
  - stimulus: a read of 0x40 accepted at edge T;
  - response: hready_o=0 for cycles T+1..T+3, hready_o=1 in cycle T+4 with valid hrdata_o, and an address presented in the wait cycles is not accepted.
- **Reset mid-write:**
  - stimulus: accept a write of 0x55 to 0x50 with WAIT_STATES=2, then assert resetn_i during the WAIT state;
  - response: the subsequent read of 0x50 returns the old contents.
